// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with per-stage carry
// segments, status flags and valid/ready handshake on both sides.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG = WIDTH / STAGES;

    logic              advance;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] c_q, c_d, c_s;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  a_s [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  b_s [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [SEG:0]      sum [STAGES];
    logic              ov_q, ov_d;
    logic              z_q, z_d;

    // Global stall: the whole pipe holds when the last stage cannot retire.
    assign advance = out_ready | ~valid_q[STAGES-1];

    always_comb begin
        a_s[0] = op1;
        b_s[0] = op2 ^ {WIDTH{sub}};
        r_s[0] = '0;
        c_s[0] = carry_in ^ sub;
        valid_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_s[k] = a_q[k-1];
            b_s[k] = b_q[k-1];
            r_s[k] = r_q[k-1];
            c_s[k] = c_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sum[k] = {1'b0, a_s[k][k*SEG +: SEG]}
                   + {1'b0, b_s[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_s[k]};
            a_d[k] = a_s[k];
            b_d[k] = b_s[k];
            r_d[k] = r_s[k];
            r_d[k][k*SEG +: SEG] = sum[k][SEG-1:0];
            c_d[k] = sum[k][SEG];
        end
        // a ^ b ^ sum at the MSB recovers the carry into the MSB.
        ov_d = a_s[STAGES-1][WIDTH-1]
             ^ b_s[STAGES-1][WIDTH-1]
             ^ r_d[STAGES-1][WIDTH-1]
             ^ c_d[STAGES-1];
        z_d = (r_d[STAGES-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            c_q     <= '0;
            ov_q    <= 1'b0;
            z_q     <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
            z_q     <= z_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign result    = r_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    assign overflow  = ov_q;
    assign zero      = z_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations share one stimulus
// stream, each checked by its own scoreboard against a whole-word model.
module tb_pipelined_addsub;

    typedef struct {
        logic [63:0] r;
        logic        c;
        logic        ov;
        logic        z;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sub;
    logic        cin;
    logic [63:0] op1;
    logic [63:0] op2;

    logic        rdy64, ov64, co64, of64, z64;
    logic [63:0] res64;
    logic        rdy32, ov32, co32, of32, z32;
    logic [31:0] res32;
    logic        rdy16, ov16, co16, of16, z16;
    logic [15:0] res16;

    int   vectors = 0;
    int   miscompares = 0;
    int   adv [3];
    bit   acc [3];
    exp_t q [3][$];

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(64), .STAGES(4)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .op1(op1), .op2(op2), .sub(sub), .carry_in(cin),
        .out_valid(ov64), .out_ready(out_ready), .result(res64),
        .carry_out(co64), .overflow(of64), .zero(z64)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .op1(op1[31:0]), .op2(op2[31:0]), .sub(sub), .carry_in(cin),
        .out_valid(ov32), .out_ready(out_ready), .result(res32),
        .carry_out(co32), .overflow(of32), .zero(z32)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .op1(op1[15:0]), .op2(op2[15:0]), .sub(sub), .carry_in(cin),
        .out_valid(ov16), .out_ready(out_ready), .result(res16),
        .carry_out(co16), .overflow(of16), .zero(z16)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Whole-word reference: plain arithmetic on a w-bit slice.
    function automatic exp_t model(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input logic s,
                                   input logic ci);
        logic [64:0] m, aa, bb, full;
        exp_t e;
        m    = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & m;
        bb   = (s ? ~{1'b0, b} : {1'b0, b}) & m;
        full = aa + bb + {64'd0, ci ^ s};
        e.r  = full[63:0] & m[63:0];
        e.c  = full[w];
        e.ov = (aa[w-1] == bb[w-1]) && (e.r[w-1] != aa[w-1]);
        e.z  = (e.r == 64'd0);
        e.tag = 0;
        return e;
    endfunction

    task automatic sbstep(input int i, input int w, input int s,
                          input logic rdy, input logic vld,
                          input logic [63:0] r, input logic c,
                          input logic ovf, input logic z);
        exp_t e;
        acc[i] = 1'b0;
        if (vld && out_ready) begin
            chk1($sformatf("u%0d_spurious", i), q[i].size() != 0, 1'b1);
            if (q[i].size() != 0) begin
                e = q[i].pop_front();
                chk($sformatf("u%0d_result", i), r, e.r);
                chk1($sformatf("u%0d_carry", i), c, e.c);
                chk1($sformatf("u%0d_overflow", i), ovf, e.ov);
                chk1($sformatf("u%0d_zero", i), z, e.z);
                chk($sformatf("u%0d_latency", i),
                    64'(adv[i] - e.tag), 64'(s));
            end
        end
        if (in_valid && rdy) begin
            e = model(w, op1, op2, sub, cin);
            e.tag = adv[i];
            q[i].push_back(e);
            acc[i] = 1'b1;
        end
        if (rdy) adv[i]++;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next one.
    task automatic cyc();
        #1;
        sbstep(0, 64, 4, rdy64, ov64, res64, co64, of64, z64);
        sbstep(1, 32, 1, rdy32, ov32, {32'd0, res32}, co32, of32, z32);
        sbstep(2, 16, 16, rdy16, ov16, {48'd0, res16}, co16, of16, z16);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [63:0] a,
                            input logic [63:0] b, input logic s,
                            input logic ci, input logic [63:0] er,
                            input logic ec, input logic eov,
                            input logic ez);
        in_valid = 1'b1; out_ready = 1'b1;
        op1 = a; op2 = b; sub = s; cin = ci;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1({tag, "_early"}, ov64, 1'b0);
            cyc();
        end
        chk1({tag, "_valid"}, ov64, 1'b1);
        chk({tag, "_result"}, res64, er);
        chk1({tag, "_carry"}, co64, ec);
        chk1({tag, "_overflow"}, of64, eov);
        chk1({tag, "_zero"}, z64, ez);
    endtask

    task automatic rand_ops();
        op1 = {$urandom(), $urandom()};
        op2 = {$urandom(), $urandom()};
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    initial begin
        exp_t e;
        int   sent;
        for (int i = 0; i < 3; i++) adv[i] = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; sub = 1'b0; cin = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_out_valid", ov64, 1'b0);
        chk("rst_result", res64, 64'd0);
        chk1("rst_carry", co64, 1'b0);
        chk1("rst_overflow", of64, 1'b0);
        chk1("rst_zero", z64, 1'b0);
        chk1("rst_in_ready", rdy64, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        directed("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                 64'h0, 1'b1, 1'b0, 1'b1);
        directed("sub_5_7", 64'd5, 64'd7, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_7_5_b", 64'd7, 64'd5, 1'b1, 1'b1,
                 64'h1, 1'b1, 1'b0, 1'b0);
        directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        directed("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();

        // Eight back-to-back requests with a three-cycle output stall.
        sent = 0;
        rand_ops();
        for (int it = 0; it < 40 && sent < 8; it++) begin
            in_valid  = 1'b1;
            out_ready = !(it >= 4 && it < 7);
            if (it >= 4 && it < 7) begin
                #1;
                chk1("stall_in_ready", rdy64, 1'b0);
                chk1("stall_out_valid", ov64, 1'b1);
                chk("stall_result", res64,
                    q[0].size() > 0 ? q[0][0].r : 64'hx);
            end
            cyc();
            if (acc[0]) begin
                sent++;
                rand_ops();
            end
        end
        chk("stream_sent", 64'(sent), 64'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();

        // Reset with three requests in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            cyc();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk1("mrst_out_valid", ov64, 1'b0);
        chk("mrst_result", res64, 64'd0);
        chk1("mrst_carry", co64, 1'b0);
        chk1("mrst_overflow", of64, 1'b0);
        chk1("mrst_zero", z64, 1'b0);
        chk1("mrst_in_ready", rdy64, 1'b1);
        for (int i = 0; i < 3; i++) q[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        e = model(64, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321,
                  1'b1, 1'b0);
        directed("post_rst", 64'h0123_4567_89AB_CDEF,
                 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
                 e.r, e.c, e.ov, e.z);

        // Random traffic with random back-pressure on all three configurations.
        for (int it = 0; it < 400; it++) begin
            rand_ops();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) cyc();
        for (int i = 0; i < 3; i++)
            chk($sformatf("u%0d_drained", i), 64'(q[i].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the next generation of the team's 64-bit ripple-carry adder, generalised in WIDTH and pipeline depth, with per-transaction add/sub mode, status flags and a valid/ready handshake on both sides. Each pipeline stage adds one WIDTH/STAGES-bit segment and registers the carry into the next stage. It sits in the ALU datapath ahead of the result mux, and sustains one operation per cycle.

Parameters:
WIDTH, 64, operand/result width in bits; must be >= 2.
STAGES, 4, number of pipeline stages (= latency in cycles); must divide WIDTH exactly; STAGES=1 is legal.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block accepts the request this cycle
op1  input  WIDTH  operand A
op2  input  WIDTH  operand B
sub  input  1  0 = add, 1 = subtract
carry_in  input  1  add: carry in; sub: borrow in (1 = borrow)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
result  output  WIDTH  sum/difference
carry_out  output  1  raw adder carry out of the MSB (sub: 1 = no borrow)
overflow  output  1  signed overflow
zero  output  1  result == 0

Behaviour:
- Arithmetic: result = op1 + (op2 XOR {WIDTH{sub}}) + (carry_in XOR sub), modulo 2^WIDTH. carry_out is bit WIDTH of the same sum. overflow = carry into MSB XOR carry out of MSB. zero = (result == 0).
- Segmentation: SEG = WIDTH/STAGES. Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses (carry_in XOR sub). Unprocessed upper operand segments and completed lower result segments travel with the transaction in the stage registers. The flags are computed in the last stage.
- Handshake: a transfer occurs on a rising clk edge when valid and ready are both high. advance = out_ready OR NOT valid_q[STAGES-1]. in_ready = advance, which is combinational from out_ready and state only. in_ready does not depend on in_valid.
- Advance behaviour: when advance=1, all stages shift by one, valid_q[0] <= in_valid, and valid_q[k] <= valid_q[k-1]. When advance=0, all stage registers hold (global stall) and bubbles are not compressed.
- Latency: an accepted request appears on the outputs exactly STAGES cycles later, provided no stall occurs. Results emerge in acceptance order. Throughput is 1 per cycle with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, result, carry_out, overflow and zero hold stable.
- Bubbles: stages that carry no valid transaction may hold any data, but out_valid=0 for them.
- Reset: rst_n low asynchronously clears all valid_q bits, the data registers and the output registers. During reset out_valid=0, result=0, carry_out=0, overflow=0, zero=0, and in_ready=1 (pipeline empty). In-flight transactions are discarded with no partial output.
- Simultaneous accept and emit: when the pipeline is full and out_ready=1, the block accepts a new request on the same edge the oldest result retires.
- STAGES=1: a single registered stage with the same handshake and a latency of 1.

Test Plan:
- WIDTH=64, STAGES=4: add 0xFFFF_FFFF_FFFF_FFFF + 0x1, carry_in=0 -> 4 cycles later result=0, carry_out=1, zero=1, overflow=0.
- Subtract 5 - 7, carry_in=0 -> result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0, zero=0. Subtract 7 - 5 with carry_in=1 -> result=1, carry_out=1.
- Add 0x7FFF_FFFF_FFFF_FFFF + 1 -> result=0x8000_0000_0000_0000, overflow=1, carry_out=0. Subtract 0x8000_0000_0000_0000 - 1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Stream 8 back-to-back random requests and drop out_ready for 3 cycles in the middle -> in_ready falls in the same cycle the last stage holds a valid result. Outputs hold stable during the stall, no request is lost or duplicated, order is preserved, and all 8 results match the reference model.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 requests in flight -> out_valid=0 and all outputs 0 immediately. After release, the next request returns alone after 4 cycles.
- Regression at WIDTH=32, STAGES=1 and at WIDTH=16, STAGES=16: random add/sub with random stalls -> every result and flag matches the reference model, with latency equal to STAGES.
